// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ALU op encodings, datapath widths and the
// control-field bubble loaded into the ID/EX register on a kill or stall.
package cpu_defs;

  localparam int DATA_WIDTH     = 32;
  localparam int SEL_WIDTH      = 4;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [SEL_WIDTH-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  // Single-bit controls carried through the ID/EX register.
  typedef struct packed {
    logic valid;
    logic use_imm;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  // A bubble does nothing: no valid flag, no writes, no memory access.
  localparam ex_ctrl_t CTRL_BUBBLE = '{
    valid: 1'b0, use_imm: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0
  };

  // Opcode carried by a bubble.
  localparam alu_op_e OP_BUBBLE = ALU_ADD;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way priority forwarding select for one ALU source operand.
// EX/MEM beats MEM/WB beats the register-file value; register 0 is never forwarded.
module fwd_mux
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH     = cpu_defs::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_defs::REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     fwd
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
  assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

  // Younger producer (EX/MEM) wins when both stages target the same register.
  always_comb begin
    fwd = reg_data;
    if (hit_exmem)      fwd = exmem_result;
    else if (hit_memwb) fwd = memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Feeds the ALU directly; forwarding acts on the registered source indices.
module id_ex_stage
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH     = cpu_defs::DATA_WIDTH,
  parameter int SEL_WIDTH      = cpu_defs::SEL_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_defs::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_uses_rt,
  input  logic [DATA_WIDTH-1:0]     id_rs_data,
  input  logic [DATA_WIDTH-1:0]     id_rt_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [4:0]                id_shamt,
  input  logic [SEL_WIDTH-1:0]      id_alu_op,
  input  logic                      id_use_imm,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     alu_operand1,
  output logic [DATA_WIDTH-1:0]     alu_operand2,
  output logic [4:0]                alu_shamt,
  output logic [SEL_WIDTH-1:0]      alu_opSel,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write
);

  ex_ctrl_t                  ctrl;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]     rs_data;
  logic [DATA_WIDTH-1:0]     rt_data;
  logic [DATA_WIDTH-1:0]     imm;
  logic [4:0]                shamt;
  logic [SEL_WIDTH-1:0]      alu_op;
  logic                      load_bubble;
  logic [DATA_WIDTH-1:0]     fwd_rs;
  logic [DATA_WIDTH-1:0]     fwd_rt;

  // Load-use: the load in EX has not produced data yet, so hold decode one cycle.
  assign stall = ctrl.valid && ctrl.mem_read && (rd != '0) && id_valid &&
                 ((rd == id_rs) || (id_uses_rt && (rd == id_rt)));

  // Flush, stall and an empty decode slot all insert a bubble.
  assign load_bubble = flush || stall || !id_valid;

  // Pipeline register: bubble clears every field, otherwise capture decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= CTRL_BUBBLE;
      rs      <= '0;
      rt      <= '0;
      rd      <= '0;
      rs_data <= '0;
      rt_data <= '0;
      imm     <= '0;
      shamt   <= '0;
      alu_op  <= SEL_WIDTH'(OP_BUBBLE);
    end else if (load_bubble) begin
      ctrl    <= CTRL_BUBBLE;
      rs      <= '0;
      rt      <= '0;
      rd      <= '0;
      rs_data <= '0;
      rt_data <= '0;
      imm     <= '0;
      shamt   <= '0;
      alu_op  <= SEL_WIDTH'(OP_BUBBLE);
    end else begin
      ctrl.valid     <= 1'b1;
      ctrl.use_imm   <= id_use_imm;
      ctrl.reg_write <= id_reg_write;
      ctrl.mem_read  <= id_mem_read;
      ctrl.mem_write <= id_mem_write;
      rs             <= id_rs;
      rt             <= id_rt;
      rd             <= id_rd;
      rs_data        <= id_rs_data;
      rt_data        <= id_rt_data;
      imm            <= id_imm;
      shamt          <= id_shamt;
      alu_op         <= id_alu_op;
    end
  end

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs (
    .src             (rs),
    .reg_data        (rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd             (fwd_rs)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rt (
    .src             (rt),
    .reg_data        (rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd             (fwd_rt)
  );

  assign ex_valid      = ctrl.valid;
  assign ex_reg_write  = ctrl.reg_write;
  assign ex_mem_read   = ctrl.mem_read;
  assign ex_mem_write  = ctrl.mem_write;
  assign ex_rd         = rd;
  assign alu_shamt     = shamt;
  assign alu_opSel     = alu_op;
  assign alu_operand1  = fwd_rs;
  assign alu_operand2  = ctrl.use_imm ? imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of single-transaction vectors checked through a
// scoreboard queue, plus hand-written load-use, flush+stall and reset sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_op;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall, ex_valid;
  logic [31:0] alu_operand1, alu_operand2, ex_store_data;
  logic [4:0]  alu_shamt, ex_rd;
  logic [3:0]  alu_opSel;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_shamt(alu_shamt), .alu_opSel(alu_opSel),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  typedef struct {
    string       name;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt;
    logic [3:0]  op;
    logic        use_imm, rw, mr, mw;
    logic        xm_rw;
    logic [4:0]  xm_rd;
    logic [31:0] xm_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [31:0] e_op1, e_op2, e_st;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] op1, op2, st;
    logic [4:0]  shamt, rd;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alu_op = 0;
    id_use_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic drive_lw();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd0; id_rd = 5'd8; id_uses_rt = 0;
    id_rs_data = 32'h1000; id_rt_data = 0; id_imm = 32'd4; id_shamt = 0;
    id_alu_op = 4'd0; id_use_imm = 1; id_reg_write = 1; id_mem_read = 1; id_mem_write = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_op1"}, alu_operand1, 32'd0);
    chk({tag, "_op2"}, alu_operand2, 32'd0);
    chk({tag, "_store"}, ex_store_data, 32'd0);
    chk({tag, "_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, "_opsel"}, 32'(alu_opSel), 32'd0);
    chk({tag, "_shamt"}, 32'(alu_shamt), 32'd0);
    chk({tag, "_ctrl"}, {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
  endtask

  function automatic vec_t mk(input string n,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic uses_rt,
      input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
      input logic [4:0] sh, input logic [3:0] op, input logic use_imm,
      input logic rw, input logic mr, input logic mw,
      input logic xrw, input logic [4:0] xrd, input logic [31:0] xres,
      input logic wrw, input logic [4:0] wrd, input logic [31:0] wres,
      input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] es);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.rd = rd; v.uses_rt = uses_rt;
    v.rs_data = rsd; v.rt_data = rtd; v.imm = imm; v.shamt = sh; v.op = op;
    v.use_imm = use_imm; v.rw = rw; v.mr = mr; v.mw = mw;
    v.xm_rw = xrw; v.xm_rd = xrd; v.xm_res = xres;
    v.wb_rw = wrw; v.wb_rd = wrd; v.wb_res = wres;
    v.e_op1 = e1; v.e_op2 = e2; v.e_st = es;
    return v;
  endfunction

  initial begin
    exp_t e;
    rst = 0;
    idle_inputs();

    vecs[0] = mk("fwd_exmem_wins", 5, 6, 10, 1, 32'h99, 32'h66, 0, 0, 4'd1, 0, 1, 0, 0,
                 1, 5, 32'h11, 1, 5, 32'h22, 32'h11, 32'h66, 32'h66);
    vecs[1] = mk("fwd_memwb", 5, 6, 10, 1, 32'h99, 32'h66, 0, 0, 4'd1, 0, 1, 0, 0,
                 0, 5, 32'h11, 1, 5, 32'h22, 32'h22, 32'h66, 32'h66);
    vecs[2] = mk("reg0_no_fwd", 0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0,
                 1, 0, 32'hFFFF, 1, 0, 32'hEEEE, 0, 0, 0);
    vecs[3] = mk("imm_shift", 1, 7, 3, 0, 32'h100, 32'h1, 32'hFFFFFFFC, 3, 4'd7, 1, 1, 0, 0,
                 0, 7, 32'h55, 1, 7, 32'h7, 32'h100, 32'hFFFFFFFC, 32'h7);
    vecs[4] = mk("rt_both_match", 2, 9, 4, 1, 32'h20, 32'h90, 0, 0, 4'd2, 0, 1, 0, 0,
                 1, 9, 32'hAA, 1, 9, 32'hBB, 32'h20, 32'hAA, 32'hAA);
    vecs[5] = mk("store_no_match", 3, 4, 0, 1, 32'h1234, 32'h4444, 32'h8, 0, 4'd0, 1, 0, 0, 1,
                 1, 5, 32'hAA, 1, 6, 32'hBB, 32'h1234, 32'h8, 32'h4444);
    vecs[6] = mk("writes_disabled", 5, 5, 5, 1, 32'h5555, 32'h5555, 0, 0, 4'd3, 0, 1, 0, 0,
                 0, 5, 32'hAA, 0, 5, 32'hBB, 32'h5555, 32'h5555, 32'h5555);
    vecs[7] = mk("split_sources", 12, 13, 14, 1, 32'h1, 32'h2, 0, 31, 4'd8, 0, 1, 0, 0,
                 1, 13, 32'hCC, 1, 12, 32'hDD, 32'hDD, 32'hCC, 32'hCC);

    // Reset state while reset is held
    @(posedge clk); #1;
    check_all_zero("reset_initial");
    @(posedge clk); #1;
    rst = 1;

    // Table: drive ID, push expectation, check one cycle later with forwarding inputs applied
    for (int i = 0; i < 8; i++) begin
      id_valid = 1; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
      id_uses_rt = vecs[i].uses_rt; id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data;
      id_imm = vecs[i].imm; id_shamt = vecs[i].shamt; id_alu_op = vecs[i].op;
      id_use_imm = vecs[i].use_imm; id_reg_write = vecs[i].rw; id_mem_read = vecs[i].mr;
      id_mem_write = vecs[i].mw;
      e.name = vecs[i].name; e.op1 = vecs[i].e_op1; e.op2 = vecs[i].e_op2; e.st = vecs[i].e_st;
      e.shamt = vecs[i].shamt; e.rd = vecs[i].rd; e.op = vecs[i].op;
      e.rw = vecs[i].rw; e.mr = vecs[i].mr; e.mw = vecs[i].mw;
      sb.push_back(e);
      @(posedge clk); #1;
      exmem_reg_write = vecs[i].xm_rw; exmem_rd = vecs[i].xm_rd; exmem_result = vecs[i].xm_res;
      memwb_reg_write = vecs[i].wb_rw; memwb_rd = vecs[i].wb_rd; memwb_result = vecs[i].wb_res;
      #1;
      e = sb.pop_front();
      $display("txn %0d %s op1=%h op2=%h store=%h shamt=%0d opsel=%0d rd=%0d", i, e.name,
               alu_operand1, alu_operand2, ex_store_data, alu_shamt, alu_opSel, ex_rd);
      chk({e.name, "_valid"}, 32'(ex_valid), 32'd1);
      chk({e.name, "_op1"}, alu_operand1, e.op1);
      chk({e.name, "_op2"}, alu_operand2, e.op2);
      chk({e.name, "_store"}, ex_store_data, e.st);
      chk({e.name, "_shamt"}, 32'(alu_shamt), 32'(e.shamt));
      chk({e.name, "_opsel"}, 32'(alu_opSel), 32'(e.op));
      chk({e.name, "_rd"}, 32'(ex_rd), 32'(e.rd));
      chk({e.name, "_ctrl"}, {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
          {29'd0, e.rw, e.mr, e.mw});
      chk({e.name, "_stall"}, 32'(stall), 32'd0);
    end

    // Load-use: lw rd=8 then add rs=8
    idle_inputs();
    drive_lw();
    @(posedge clk); #1;
    id_valid = 1; id_rs = 8; id_rt = 2; id_rd = 9; id_uses_rt = 1; id_rs_data = 0;
    id_rt_data = 32'h3; id_imm = 0; id_use_imm = 0; id_reg_write = 1; id_mem_read = 0;
    id_mem_write = 0; id_alu_op = 4'd0;
    #1;
    $display("txn loaduse_detect stall=%0d", stall);
    chk("loaduse_stall_high", 32'(stall), 32'd1);
    @(posedge clk); #1;
    $display("txn loaduse_bubble ex_valid=%0d stall=%0d", ex_valid, stall);
    chk("loaduse_bubble_valid", 32'(ex_valid), 32'd0);
    chk("loaduse_bubble_rw", 32'(ex_reg_write), 32'd0);
    chk("loaduse_stall_one_cycle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    exmem_reg_write = 0; memwb_reg_write = 1; memwb_rd = 8; memwb_result = 32'h5A5A;
    #1;
    $display("txn loaduse_resume ex_valid=%0d op1=%h op2=%h", ex_valid, alu_operand1, alu_operand2);
    chk("loaduse_resume_valid", 32'(ex_valid), 32'd1);
    chk("loaduse_resume_op1", alu_operand1, 32'h5A5A);
    chk("loaduse_resume_op2", alu_operand2, 32'h3);
    chk("loaduse_resume_rd", 32'(ex_rd), 32'd9);

    // Flush and stall together
    idle_inputs();
    drive_lw();
    @(posedge clk); #1;
    id_valid = 1; id_rs = 8; id_rt = 0; id_rd = 10; id_uses_rt = 0; id_use_imm = 0;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 1; flush = 1;
    #1;
    chk("flush_stall_stall_high", 32'(stall), 32'd1);
    @(posedge clk); #1;
    $display("txn flush_stall ex_valid=%0d rw=%0d mw=%0d", ex_valid, ex_reg_write, ex_mem_write);
    chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    chk("flush_stall_rw", 32'(ex_reg_write), 32'd0);
    chk("flush_stall_mw", 32'(ex_mem_write), 32'd0);

    // Reset asserted mid-stall
    idle_inputs();
    drive_lw();
    @(posedge clk); #1;
    id_valid = 1; id_rs = 8; id_reg_write = 1; id_mem_read = 0; id_use_imm = 0;
    #1;
    chk("midreset_stall_before", 32'(stall), 32'd1);
    rst = 0;
    #1;
    $display("txn midreset ex_valid=%0d stall=%0d", ex_valid, stall);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
